// File: rtl/avalon_st_reader.sv
// avalon_st_reader
// Avalon-ST sink for the read side of a FIFO. It drives a registered ready
// towards the FIFO, honouring READY_LATENCY / READY_ALLOWANCE. Captured beats
// go into a circular skid buffer, and the buffer head is re-presented on a
// zero-latency valid/ready port. It also counts accepted beats and keeps
// sticky overflow and protocol error flags.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   en           run enable
//   data_rd      beat data from the FIFO
//   valid_rd     beat valid from the FIFO
//   ready_rd     ready to the FIFO (registered)
//   out_data     head of the skid buffer (0 when empty)
//   out_valid    skid buffer non-empty
//   out_ready    downstream accept
//   beat_cnt     beats accepted into the buffer, wraps at 2^32
//   err_overflow sticky: beat dropped because the buffer was full
//   err_protocol sticky: beat outside the legal ready window, or while idle
//   clr_err      synchronous clear of both error flags (a new error wins)
module avalon_st_reader #(
  parameter int DATABITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT    = 4,
  parameter int WIDTH               = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL,
  parameter int READY_LATENCY       = 1,
  parameter int READY_ALLOWANCE     = 2,
  parameter int SKID_DEPTH          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] data_rd,
  input  logic             valid_rd,
  output logic             ready_rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      beat_cnt,
  output logic             err_overflow,
  output logic             err_protocol,
  input  logic             clr_err
);

  localparam int H  = READY_LATENCY + READY_ALLOWANCE + 1;
  localparam int AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam int SW = $clog2(H + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(SKID_DEPTH);
  localparam logic [CW-1:0] READY_MAX = CW'(SKID_DEPTH - H);
  localparam logic [AW-1:0] LAST_PTR  = AW'(SKID_DEPTH - 1);
  localparam logic [SW-1:0] STOP_LOAD = SW'(READY_LATENCY + READY_ALLOWANCE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_e;

  state_e            state_q;
  logic [SW-1:0]     stop_cnt_q;
  logic [H-1:0]      hist_q, hist_d;
  logic [WIDTH-1:0]  mem [SKID_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       beat_cnt_q, beat_cnt_d;
  logic              err_ovf_q, err_ovf_d, err_prot_q, err_prot_d;
  logic              capture, legal, push, pop, ready_d;

  // hist_q[0] is the ready being presented this cycle; hist_q[k] is the
  // value from k cycles ago. A beat is legal if any of hist_q[L..L+A] is set.
  always_comb begin
    legal = 1'b0;
    for (int unsigned i = READY_LATENCY; i < H; i++) begin
      legal = legal | hist_q[i];
    end
  end

  always_comb begin
    capture = valid_rd && (state_q != IDLE);
    pop     = (count_q != '0) && out_ready;
    // A full buffer still takes a beat when the head leaves in the same cycle.
    push    = capture && ((count_q != DEPTH_C) || pop);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    rd_ptr_d = rd_ptr_q;
    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);

    beat_cnt_d = beat_cnt_q + 32'(push);
    err_ovf_d  = (err_ovf_q & ~clr_err) | (capture & ~push);
    err_prot_d = (err_prot_q & ~clr_err) |
                 (valid_rd & ((state_q == IDLE) | ~legal));

    ready_d = (state_q == RUN) && en && (count_d <= READY_MAX);

    hist_d    = '0;
    hist_d[0] = ready_d;
    for (int unsigned i = 1; i < H; i++) begin
      hist_d[i] = hist_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      stop_cnt_q <= '0;
      hist_q     <= '0;
    end else begin
      hist_q <= hist_d;
      case (state_q)
        IDLE: if (en) state_q <= RUN;
        RUN: begin
          if (!en) begin
            state_q    <= STOP;
            stop_cnt_q <= STOP_LOAD;
          end
        end
        STOP: begin
          if (en)                    state_q    <= RUN;
          else if (stop_cnt_q == '0) state_q    <= IDLE;
          else                       stop_cnt_q <= stop_cnt_q - SW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
      err_ovf_q  <= 1'b0;
      err_prot_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      beat_cnt_q <= beat_cnt_d;
      err_ovf_q  <= err_ovf_d;
      err_prot_q <= err_prot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_rd;
  end

  // Storage is not reset; gating on count makes stale entries invisible.
  assign out_valid    = (count_q != '0);
  assign out_data     = out_valid ? mem[rd_ptr_q] : '0;
  assign ready_rd     = hist_q[0];
  assign beat_cnt     = beat_cnt_q;
  assign err_overflow = err_ovf_q;
  assign err_protocol = err_prot_q;

endmodule

// File: tb/tb_avalon_st_reader.sv
module tb_avalon_st_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [31:0] data_rd = '0;
  logic        valid_rd = 1'b0;
  logic        ready_rd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] beat_cnt;
  logic        err_overflow;
  logic        err_protocol;
  logic        clr_err = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_st_reader #(
    .DATABITS_PER_SYMBOL(8),
    .SYMBOLS_PER_BEAT(4),
    .READY_LATENCY(1),
    .READY_ALLOWANCE(2),
    .SKID_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .data_rd(data_rd),
    .valid_rd(valid_rd),
    .ready_rd(ready_rd),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .beat_cnt(beat_cnt),
    .err_overflow(err_overflow),
    .err_protocol(err_protocol),
    .clr_err(clr_err)
  );

  task automatic do_reset();
    rst       = 1'b0;
    en        = 1'b0;
    valid_rd  = 1'b0;
    data_rd   = '0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Leaves the caller at the negedge of the first cycle with ready_rd high.
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_rd === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready_rd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (beat_cnt !== 32'h0) begin errors++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err_overflow: got %b want 0", err_overflow); end
    checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL reset_err_protocol: got %b want 0", err_protocol); end
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", ready_rd); end
  endtask

  task automatic test_basic_stream();
    int mcount, sent, head;
    bit prev_r, push, pop;
    do_reset();
    en = 1'b1;
    out_ready = 1'b1;
    mcount = 0; sent = 0; head = 0; prev_r = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc >= 1) begin
        checks++; if (ready_rd !== 1'b1) begin errors++; $display("FAIL basic_ready cyc%0d: got %b want 1", cyc, ready_rd); end
      end
      checks++; if (out_valid !== (mcount != 0)) begin errors++; $display("FAIL basic_out_valid cyc%0d: got %b want %b", cyc, out_valid, mcount != 0); end
      if (mcount != 0) begin
        checks++; if (out_data !== 32'(head + 1)) begin errors++; $display("FAIL basic_out_data cyc%0d: got %h want %h", cyc, out_data, head + 1); end
      end
      pop  = (mcount != 0);
      push = prev_r && (sent < 16);
      valid_rd = push;
      data_rd  = 32'(sent + 1);
      if (push) sent++;
      if (pop) head++;
      mcount = mcount + (push ? 1 : 0) - (pop ? 1 : 0);
      prev_r = ready_rd;
    end
    valid_rd = 1'b0;
    checks++; if (beat_cnt !== 32'd16) begin errors++; $display("FAIL basic_beat_cnt: got %0d want 16", beat_cnt); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL basic_err_overflow: got %b want 0", err_overflow); end
    checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL basic_err_protocol: got %b want 0", err_protocol); end
  endtask

  task automatic test_backpressure();
    int mcount, sent, head;
    bit prev_r, push, pop;
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    mcount = 0; sent = 0; head = 0; prev_r = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (cyc >= 1) begin
        checks++; if (ready_rd !== (mcount <= 4)) begin errors++; $display("FAIL bp_ready cyc%0d: got %b want %b", cyc, ready_rd, mcount <= 4); end
      end
      checks++; if (out_valid !== (mcount != 0)) begin errors++; $display("FAIL bp_out_valid cyc%0d: got %b want %b", cyc, out_valid, mcount != 0); end
      if (mcount != 0) begin
        checks++; if (out_data !== 32'(32'h101 + head)) begin errors++; $display("FAIL bp_out_data cyc%0d: got %h want %h", cyc, out_data, 32'h101 + head); end
      end
      if (cyc == 19) begin
        checks++; if (beat_cnt !== 32'd6) begin errors++; $display("FAIL bp_buffered: got %0d want 6", beat_cnt); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL bp_err_overflow: got %b want 0", err_overflow); end
      end
      if (cyc == 20) out_ready = 1'b1;
      pop  = (mcount != 0) && out_ready;
      push = prev_r && (sent < 10);
      valid_rd = push;
      data_rd  = 32'(32'h101 + sent);
      if (push) sent++;
      if (pop) head++;
      mcount = mcount + (push ? 1 : 0) - (pop ? 1 : 0);
      prev_r = ready_rd;
    end
    valid_rd = 1'b0;
    checks++; if (beat_cnt !== 32'd10) begin errors++; $display("FAIL bp_beat_cnt: got %0d want 10", beat_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL bp_err_protocol: got %b want 0", err_protocol); end
  endtask

  task automatic test_allowance();
    bit ok;
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL allow_ready_timeout: got no ready want ready"); end
    // Beats fill to 5 so ready falls in cycle c+6; c+8 is the last legal cycle.
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 5) begin
        checks++; if (ready_rd !== 1'b1) begin errors++; $display("FAIL allow_ready_high: got %b want 1", ready_rd); end
      end
      if (k == 6) begin
        checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL allow_ready_fall: got %b want 0", ready_rd); end
      end
      if (k == 9) begin
        checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL allow_edge_legal: got %b want 0", err_protocol); end
      end
      if (k == 10) begin
        checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL allow_edge_illegal: got %b want 1", err_protocol); end
      end
      if (k == 11) begin
        checks++; if (beat_cnt !== 32'd7) begin errors++; $display("FAIL allow_beat_cnt: got %0d want 7", beat_cnt); end
      end
      valid_rd = (k <= 5) || (k == 8) || (k == 9);
      data_rd  = 32'(32'h300 + k);
    end
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL allow_clr: got %b want 0", err_protocol); end
    valid_rd = 1'b1;
    data_rd  = 32'h3FF;
    clr_err  = 1'b1;
    @(negedge clk);
    valid_rd = 1'b0;
    clr_err  = 1'b0;
    checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL allow_clr_vs_new: got %b want 1", err_protocol); end
    checks++; if (beat_cnt !== 32'd8) begin errors++; $display("FAIL allow_beat_cnt2: got %0d want 8", beat_cnt); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL allow_err_overflow: got %b want 0", err_overflow); end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [31:0] exp;
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_ready_timeout: got no ready want ready"); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      valid_rd = 1'b1;
      data_rd  = 32'(32'hA0 + k);
    end
    @(negedge clk);
    valid_rd = 1'b0;
    clr_err  = 1'b1;
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", err_overflow); end
    checks++; if (beat_cnt !== 32'd8) begin errors++; $display("FAIL ovf_beat_cnt: got %0d want 8", beat_cnt); end
    checks++; if (out_data !== 32'hA1) begin errors++; $display("FAIL ovf_head: got %h want a1", out_data); end
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", err_overflow); end
    out_ready = 1'b1;
    valid_rd  = 1'b1;
    data_rd   = 32'hAA;
    @(negedge clk);
    valid_rd = 1'b0;
    checks++; if (beat_cnt !== 32'd9) begin errors++; $display("FAIL ovf_full_pushpop_cnt: got %0d want 9", beat_cnt); end
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_full_pushpop_err: got %b want 0", err_overflow); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 32'(32'hA2 + i) : 32'hAA;
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL ovf_drain%0d: got %b/%h want 1/%h", i, out_valid, out_data, exp); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_stop_restart();
    do_reset();
    en = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL stop_ready_first: got %b want 0", ready_rd); end
    @(negedge clk);
    checks++; if (ready_rd !== 1'b1) begin errors++; $display("FAIL stop_ready_second: got %b want 1", ready_rd); end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 6) begin
        checks++; if (out_valid !== 1'b1 || out_data !== 32'(32'hB0 + k - 1)) begin errors++; $display("FAIL stop_out k%0d: got %b/%h want 1/%h", k, out_valid, out_data, 32'hB0 + k - 1); end
      end
      if (k == 3) begin
        checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL stop_ready_fall: got %b want 0", ready_rd); end
      end
      if (k == 7) begin
        checks++; if (beat_cnt !== 32'd5) begin errors++; $display("FAIL stop_inflight_cnt: got %0d want 5", beat_cnt); end
        checks++; if (err_protocol !== 1'b0) begin errors++; $display("FAIL stop_inflight_err: got %b want 0", err_protocol); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stop_drained: got %b want 0", out_valid); end
      end
      if (k == 9) begin
        checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL stop_idle_err: got %b want 1", err_protocol); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stop_idle_no_push: got %b want 0", out_valid); end
        checks++; if (beat_cnt !== 32'd5) begin errors++; $display("FAIL stop_idle_cnt: got %0d want 5", beat_cnt); end
        checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL stop_idle_ready: got %b want 0", ready_rd); end
      end
      if (k >= 2) en = 1'b0;
      if (k == 9) en = 1'b1;
      valid_rd = (k <= 5) || (k == 8);
      data_rd  = 32'(32'hB0 + k);
    end
    @(negedge clk);
    checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL restart_ready_first: got %b want 0", ready_rd); end
    @(negedge clk);
    checks++; if (ready_rd !== 1'b1) begin errors++; $display("FAIL restart_ready_second: got %b want 1", ready_rd); end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    wait_ready(ok);
    checks++; if (!ok) begin errors++; $display("FAIL arst_ready_timeout: got no ready want ready"); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      valid_rd = 1'b1;
      data_rd  = 32'(32'hC0 + k);
    end
    @(negedge clk);
    valid_rd = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b want 1", out_valid); end
    checks++; if (beat_cnt !== 32'd5) begin errors++; $display("FAIL arst_pre_cnt: got %0d want 5", beat_cnt); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b want 0", ready_rd); end
    checks++; if (beat_cnt !== 32'd0) begin errors++; $display("FAIL arst_beat_cnt: got %0d want 0", beat_cnt); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL arst_out_data: got %h want 0", out_data); end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (ready_rd !== 1'b0) begin errors++; $display("FAIL arst_idle_ready: got %b want 0", ready_rd); end
    @(negedge clk);
    checks++; if (ready_rd !== 1'b1) begin errors++; $display("FAIL arst_run_ready: got %b want 1", ready_rd); end
    @(negedge clk);
    valid_rd = 1'b1;
    data_rd  = 32'hC7;
    @(negedge clk);
    valid_rd = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hC7) begin errors++; $display("FAIL arst_after_beat: got %b/%h want 1/c7", out_valid, out_data); end
    checks++; if (beat_cnt !== 32'd1) begin errors++; $display("FAIL arst_after_cnt: got %0d want 1", beat_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_allowance();
    test_overflow();
    test_stop_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
